// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - accumulates multiplier products into a saturating group sum with valid/ready handshakes
module product_accumulator #(
    parameter int N         = 4,
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 8,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   product,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    // One spare bit above the accumulator exposes the carry used for saturation.
    localparam int PAD = ACC_W + 1 - 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               accept;
    logic [ACC_W:0]     sum_ext;

    // Handshake and result outputs come straight from registered state.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign sum       = acc_q;
    assign count     = cnt_q;
    assign overflow  = ovf_q;

    assign accept  = in_valid && in_ready;
    assign sum_ext = {1'b0, acc_q} + {{PAD{1'b0}}, product};

    // State register plus datapath registers; reset clears the whole group.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; clear overrides any accept or release.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        cnt_d = cnt_q + CW'(1);
                        // A saturated accumulator is all ones, so any further
                        // nonzero product carries out again and it stays pinned.
                        if (sum_ext[ACC_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_ext[ACC_W-1:0];
                        end
                        if (last || (cnt_q == CW'(MAX_TERMS - 1))) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

endmodule
